multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencer for the RV32I core: an FSM that steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB. It drives the control inputs of the single-cycle datapath (ALUSrc_A/B, RegWrite, Branch, PCSrc, ALUControl, MemtoReg), plus a PC write enable and an IR latch enable. It owns the request/ready handshakes to instruction and data memory, so both can have wait states.

## Interface
Parameters:
- `FETCH_TIMEOUT`, default 255: max wait cycles in FETCH before `bus_err` pulses; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset: synchronous, active-high
- `instr_code`  in  32  latched IR contents, stable from DECODE onward
- `branch_taken`  in  1  from datapath branch logic (valid in EXECUTE)
- `instr_ready`  in  1  instruction memory data valid
- `data_ready`  in  1  data memory access complete
- `instr_req`  out  1  instruction fetch request
- `IR_en`  out  1  latch instruction memory output into IR
- `data_req`  out  1  data memory request
- `data_we`  out  1  data memory write (store)
- `PC_en`  out  1  PC register update enable
- `ALUSrc_A`, `ALUSrc_B`, `RegWrite`, `Branch`  out  1 each  datapath controls
- `PCSrc`  out  2  00 PC+4, 01 branch, 10 JAL, 11 JALR
- `MemtoReg`  out  2  00 ALU, 01 load data, 10 PC+4, 11 imm
- `ALUControl`  out  4  `ALU_*` encoding from define.svh
- `instret`  out  1  one-cycle pulse per retired instruction
- `illegal_instr`  out  1  one-cycle pulse on unknown opcode
- `bus_err`  out  1  one-cycle pulse on fetch timeout

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WB. Reset enters FETCH.
- FETCH:
  - `instr_req`=1.
  - On `instr_ready`: `IR_en`=1 and go to DECODE.
  - Wait counter reaches `FETCH_TIMEOUT`: pulse `bus_err`, clear the counter, stay in FETCH and retry.
- DECODE: always one cycle, then EXECUTE.
- EXECUTE, by opcode:
  - R (0110011), I-arith (0010011), LUI (0110111), AUIPC (0010111), JAL (1101111), JALR (1100111): go to WB.
  - Load (0000011) and store (0100011): go to MEM.
  - Branch (1100011): `Branch`=1, `PC_en`=1, `PCSrc`=01 if `branch_taken` else 00, `instret`=1, go to FETCH.
  - Any other opcode: `illegal_instr`=1, `PC_en`=1, `PCSrc`=00, go to FETCH, no `instret`.
- MEM:
  - `data_req`=1; `data_we`=1 for stores only.
  - On completion, a store asserts `PC_en`, `instret` and goes to FETCH; a load goes to WB.
- WB:
  - `RegWrite`=1 for every op except branch, store and illegal.
  - `PC_en`=1 with `PCSrc`: 10 for JAL, 11 for JALR, 00 otherwise.
  - `instret`=1, go to FETCH.
- ALUControl decode:
  - R-type: from funct3 plus bit 30 (ADD/SUB, SRL/SRA).
  - I-arith: same, but bit 30 is honoured only for funct3=101, so ADDI never decodes to SUB.
  - Load, store, JALR, AUIPC: `ALU_ADD`.
  - Branch funct3 0x0/0x1/0x4/0x5/0x6/0x7: `ALU_SUB`.
  - LUI, JAL: `ALU_ADD` (result unused).
- Source and writeback selects:
  - `ALUSrc_A`=1 only for AUIPC.
  - `ALUSrc_B`=1 for all except R-type and branch.
  - `MemtoReg`: 01 load, 10 JAL/JALR, 11 LUI, else 00.
- Datapath controls depend only on state and IR. They are held constant from EXECUTE through WB, so the ALU result and address stay stable across MEM waits.
- rd=x0 writes are issued normally; the regfile masks them on read.

## Timing
- Reset:
  - The state register loads FETCH on the first `clk` edge with `rst`=1.
  - While `rst`=1, every output is forced to 0, including `instr_req`.
  - The first `instr_req` appears in the cycle after `rst` falls.
- Latency with zero-wait memories: branch 3 cycles, ALU/LUI/AUIPC/JAL/JALR 4, store 4, load 5.
- Each memory wait cycle adds exactly one cycle.
- Handshakes: a request stays high until its ready is sampled high. Ready sampled without a request is ignored.
- `PC_en`, `instret`, `IR_en`, `illegal_instr` and `bus_err` are single-cycle pulses, never asserted in consecutive cycles.
- Reset mid-instruction: the next edge returns the FSM to FETCH and suppresses that cycle's `RegWrite`, `PC_en` and `data_req`.

## Configuration
- Macro `MULTICYCLE_DATA_WAIT_EN`.
- Defined: MEM holds until `data_ready`=1.
- Undefined: MEM is exactly one cycle, `data_ready` is ignored, and the data RAM must be single-cycle.

## Test plan
- `add x3,x1,x2` with zero-wait fetch: `instret` in cycle 4; `RegWrite`=1, `ALUControl`=`ALU_ADD`, `MemtoReg`=00 in WB.
- `lw x5,4(x1)`:
  - with `MULTICYCLE_DATA_WAIT_EN` and `data_ready` delayed 3 cycles: MEM lasts 4 cycles, `data_req` held, `ALUSrc_B`=1 stable, `MemtoReg`=01 in WB.
  - without the macro: MEM lasts 1 cycle.
- `beq` with `branch_taken`=1: `PCSrc`=01 and `PC_en`=1 in cycle 3, `RegWrite` never asserted. With `branch_taken`=0: `PCSrc`=00.
- `jalr x1,0(x2)`: `PCSrc`=11, `MemtoReg`=10, `RegWrite`=1 in WB. Opcode 0x7F: `illegal_instr` pulse, PC+4, no `instret`.
- `instr_ready` held low with `FETCH_TIMEOUT`=4: `bus_err` pulses every 5th cycle while `instr_req` stays high.
- `rst` asserted during MEM of `sw`: no `data_we`/`PC_en` on that edge; `instr_req`=1 the cycle after `rst` falls.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WB with memory handshakes.
// Optional macro MULTICYCLE_DATA_WAIT_EN: MEM waits for data_ready (otherwise MEM is one cycle).
module multicycle_ctrl #(
  parameter int FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_code,
  input  logic        branch_taken,
  input  logic        instr_ready,
  input  logic        data_ready,
  output logic        instr_req,
  output logic        IR_en,
  output logic        data_req,
  output logic        data_we,
  output logic        PC_en,
  output logic        ALUSrc_A,
  output logic        ALUSrc_B,
  output logic        RegWrite,
  output logic        Branch,
  output logic [1:0]  PCSrc,
  output logic [1:0]  MemtoReg,
  output logic [3:0]  ALUControl,
  output logic        instret,
  output logic        illegal_instr,
  output logic        bus_err
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam int CW = (FETCH_TIMEOUT > 0) ? $clog2(FETCH_TIMEOUT + 1) : 1;

  logic [2:0]    state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit, mem_done;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          is_r, is_i, is_lui, is_auipc, is_jal, is_jalr;
  logic          is_load, is_store, is_branch, is_wb_op;
  logic [3:0]    alu_dec;
  logic [1:0]    pc_src_dec;
  logic          unused_inputs;

  assign opcode    = instr_code[6:0];
  assign funct3    = instr_code[14:12];
  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_wb_op  = is_r | is_i | is_lui | is_auipc | is_jal | is_jalr;

  assign unused_inputs = ^{instr_code[31], instr_code[29:15], instr_code[11:7], data_ready};

`ifdef MULTICYCLE_DATA_WAIT_EN
  assign mem_done = data_ready;
`else
  assign mem_done = 1'b1;
`endif

  assign timeout_hit = (FETCH_TIMEOUT != 0) && (wait_cnt == CW'(FETCH_TIMEOUT));

  // Bit 30 selects SUB only for R-type; for immediates it is part of the immediate except on shifts.
  always_comb begin
    alu_dec = ALU_ADD;
    if (is_r || is_i) begin
      case (funct3)
        3'b000:  alu_dec = (is_r && instr_code[30]) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_dec = ALU_SLL;
        3'b010:  alu_dec = ALU_SLT;
        3'b011:  alu_dec = ALU_SLTU;
        3'b100:  alu_dec = ALU_XOR;
        3'b101:  alu_dec = instr_code[30] ? ALU_SRA : ALU_SRL;
        3'b110:  alu_dec = ALU_OR;
        default: alu_dec = ALU_AND;
      endcase
    end else if (is_branch && funct3 != 3'b010 && funct3 != 3'b011) begin
      alu_dec = ALU_SUB;
    end
  end

  always_comb begin
    pc_src_dec = 2'b00;
    if (is_jal)         pc_src_dec = 2'b10;
    else if (is_jalr)   pc_src_dec = 2'b11;
    else if (is_branch) pc_src_dec = {1'b0, branch_taken};
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:   if (instr_ready) state_next = S_DECODE;
      S_DECODE:  state_next = S_EXECUTE;
      S_EXECUTE: begin
        if (is_wb_op)                 state_next = S_WB;
        else if (is_load || is_store) state_next = S_MEM;
        else                          state_next = S_FETCH;
      end
      S_MEM:     if (mem_done) state_next = is_store ? S_FETCH : S_WB;
      default:   state_next = S_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == S_FETCH && !instr_ready && !timeout_hit && FETCH_TIMEOUT != 0)
        wait_cnt <= wait_cnt + CW'(1);
      else
        wait_cnt <= '0;
    end
  end

  // NOTE: every output gets a default first, so no path through the case infers a latch.
  always_comb begin
    instr_req     = 1'b0;
    IR_en         = 1'b0;
    data_req      = 1'b0;
    data_we       = 1'b0;
    PC_en         = 1'b0;
    RegWrite      = 1'b0;
    Branch        = 1'b0;
    instret       = 1'b0;
    illegal_instr = 1'b0;
    bus_err       = 1'b0;
    ALUSrc_A      = 1'b0;
    ALUSrc_B      = 1'b0;
    PCSrc         = 2'b00;
    MemtoReg      = 2'b00;
    ALUControl    = ALU_ADD;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          instr_req = 1'b1;
          IR_en     = instr_ready;
          bus_err   = !instr_ready && timeout_hit;
        end
        S_EXECUTE: begin
          if (is_branch) begin
            Branch  = 1'b1;
            PC_en   = 1'b1;
            instret = 1'b1;
          end else if (!is_wb_op && !is_load && !is_store) begin
            illegal_instr = 1'b1;
            PC_en         = 1'b1;
          end
        end
        S_MEM: begin
          data_req = 1'b1;
          data_we  = is_store;
          if (is_store && mem_done) begin
            PC_en   = 1'b1;
            instret = 1'b1;
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          PC_en    = 1'b1;
          instret  = 1'b1;
        end
        default: ;
      endcase
      // Datapath selects stay fixed from EXECUTE through WB so ALU result/address hold across MEM waits.
      if (state == S_EXECUTE || state == S_MEM || state == S_WB) begin
        ALUSrc_A   = is_auipc;
        ALUSrc_B   = !(is_r || is_branch);
        PCSrc      = pc_src_dec;
        ALUControl = alu_dec;
        if (is_load)               MemtoReg = 2'b01;
        else if (is_jal || is_jalr) MemtoReg = 2'b10;
        else if (is_lui)           MemtoReg = 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-instruction phase timeline derived from
// latency rules (fetch wait, data wait, aborts) and compared cycle by cycle.
module tb_multicycle_ctrl;

  localparam int TO = 4;
`ifdef MULTICYCLE_DATA_WAIT_EN
  localparam bit DATA_WAIT = 1'b1;
`else
  localparam bit DATA_WAIT = 1'b0;
`endif

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9;

  typedef enum int {K_R, K_I, K_LUI, K_AUIPC, K_JAL, K_JALR, K_LOAD, K_STORE, K_BRANCH, K_ILL} kind_e;

  typedef struct packed {
    logic instr_req, ir_en, data_req, data_we, pc_en, reg_write, branch, instret, illegal, bus_err;
  } ctl_t;

  logic        clk, rst, branch_taken, instr_ready, data_ready;
  logic [31:0] instr_code;
  logic        instr_req, IR_en, data_req, data_we, PC_en, ALUSrc_A, ALUSrc_B, RegWrite, Branch;
  logic        instret, illegal_instr, bus_err;
  logic [1:0]  PCSrc, MemtoReg;
  logic [3:0]  ALUControl;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_ctrl #(.FETCH_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .instr_code(instr_code), .branch_taken(branch_taken),
    .instr_ready(instr_ready), .data_ready(data_ready), .instr_req(instr_req), .IR_en(IR_en),
    .data_req(data_req), .data_we(data_we), .PC_en(PC_en), .ALUSrc_A(ALUSrc_A),
    .ALUSrc_B(ALUSrc_B), .RegWrite(RegWrite), .Branch(Branch), .PCSrc(PCSrc),
    .MemtoReg(MemtoReg), .ALUControl(ALUControl), .instret(instret),
    .illegal_instr(illegal_instr), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ctl_t       got_ctl;
  logic [7:0] got_dp;
  assign got_ctl = {instr_req, IR_en, data_req, data_we, PC_en, RegWrite, Branch, instret,
                    illegal_instr, bus_err};
  assign got_dp  = {ALUSrc_A, ALUSrc_B, MemtoReg, ALUControl};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic is_legal_op(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                      7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic logic [31:0] make_code(input kind_e k);
    logic [31:0] r;
    logic [6:0]  op;
    int          bf[6] = '{0, 1, 4, 5, 6, 7};
    r  = $urandom;
    op = 7'h7f;
    case (k)
      K_R:      begin op = 7'b0110011; r[31:25] = {1'b0, r[30], 5'b0}; end
      K_I:      op = 7'b0010011;
      K_LUI:    op = 7'b0110111;
      K_AUIPC:  op = 7'b0010111;
      K_JAL:    op = 7'b1101111;
      K_JALR:   begin op = 7'b1100111; r[14:12] = 3'b000; end
      K_LOAD:   op = 7'b0000011;
      K_STORE:  op = 7'b0100011;
      K_BRANCH: begin op = 7'b1100011; r[14:12] = 3'(bf[$urandom_range(0, 5)]); end
      default: begin
        for (int t = 0; t < 200; t++) begin
          op = 7'($urandom);
          if (!is_legal_op(op)) break;
        end
      end
    endcase
    r[6:0] = op;
    return r;
  endfunction

  // Expected {ALUSrc_A, ALUSrc_B, MemtoReg, ALUControl} from instruction class and fields.
  function automatic logic [7:0] exp_dp(input kind_e k, input logic [31:0] code);
    logic [3:0] alu;
    logic [1:0] m2r;
    logic       b30;
    b30 = code[30];
    alu = ALU_ADD;
    if (k == K_R || k == K_I) begin
      case (code[14:12])
        3'd0: alu = (k == K_R && b30) ? ALU_SUB : ALU_ADD;
        3'd1: alu = ALU_SLL;
        3'd2: alu = ALU_SLT;
        3'd3: alu = ALU_SLTU;
        3'd4: alu = ALU_XOR;
        3'd5: alu = b30 ? ALU_SRA : ALU_SRL;
        3'd6: alu = ALU_OR;
        default: alu = ALU_AND;
      endcase
    end else if (k == K_BRANCH) begin
      alu = ALU_SUB;
    end
    m2r = (k == K_LOAD) ? 2'b01 : (k == K_JAL || k == K_JALR) ? 2'b10 : (k == K_LUI) ? 2'b11 : 2'b00;
    return {k == K_AUIPC, !(k == K_R || k == K_BRANCH), m2r, alu};
  endfunction

  function automatic int mem_cycles(input int d);
    return DATA_WAIT ? d + 1 : 1;
  endfunction

  // Cycles from first FETCH cycle to retirement: fetch f+1, decode, execute, mem, wb.
  function automatic int instr_len(input kind_e k, input int f, input int d);
    case (k)
      K_BRANCH, K_ILL: return f + 3;
      K_STORE:         return f + 3 + mem_cycles(d);
      K_LOAD:          return f + 4 + mem_cycles(d);
      default:         return f + 4;
    endcase
  endfunction

  task automatic step(input logic r, input logic ir, input logic dr, input logic bt,
                      input logic [31:0] cv, input ctl_t ec, input logic dv,
                      input logic [7:0] ed, input logic pv, input logic [1:0] ep,
                      input string tag);
    @(negedge clk);
    rst          = r;
    instr_ready  = ir;
    data_ready   = dr;
    branch_taken = bt;
    instr_code   = cv;
    #1;
    check({tag, "/ctl"}, {22'b0, got_ctl}, {22'b0, ec});
    if (dv) check({tag, "/dp"}, {24'b0, got_dp}, {24'b0, ed});
    if (pv) check({tag, "/pcsrc"}, {30'b0, PCSrc}, {30'b0, ep});
  endtask

  // f: cycles instr_ready stays low; d: data wait cycles; abort_at: cycle with rst=1 (-1: none).
  task automatic run_instr(input kind_e k, input logic [31:0] code, input int f, input int d,
                           input logic taken, input int abort_at);
    int m, mem0, len;
    m    = mem_cycles(d);
    mem0 = f + 3;
    len  = instr_len(k, f, d);
    for (int c = 0; c < len; c++) begin
      ctl_t        ec;
      logic        dv, pv, r, ir, dr, bt;
      logic [1:0]  ep;
      logic [7:0]  ed;
      logic [31:0] cv;
      string       tag;
      ec = '0; dv = 1'b0; pv = 1'b0; ep = 2'b00; r = 1'b0;
      ir = 1'($urandom); dr = 1'($urandom); bt = 1'($urandom);
      cv = code;
      ed = exp_dp(k, code);
      if (c <= f) begin
        tag = "fetch";
        cv  = $urandom;
        ir  = (c == f);
        ec.instr_req = 1'b1;
        ec.ir_en     = (c == f);
        ec.bus_err   = (c != f) && ((c + 1) % (TO + 1) == 0);
      end else if (c == f + 1) begin
        tag = "decode";
      end else if (c == f + 2) begin
        tag = "execute";
        dv  = (k != K_ILL);
        bt  = taken;
        if (k == K_BRANCH) begin
          ec.pc_en = 1'b1; ec.branch = 1'b1; ec.instret = 1'b1;
          pv = 1'b1; ep = {1'b0, taken};
        end else if (k == K_ILL) begin
          ec.pc_en = 1'b1; ec.illegal = 1'b1;
          pv = 1'b1; ep = 2'b00;
        end
      end else if ((k == K_LOAD || k == K_STORE) && c < mem0 + m) begin
        tag = "mem";
        dv  = 1'b1;
        ec.data_req = 1'b1;
        ec.data_we  = (k == K_STORE);
        if (DATA_WAIT) dr = (c == mem0 + d);
        if (k == K_STORE && c == mem0 + m - 1) begin
          ec.pc_en = 1'b1; ec.instret = 1'b1;
          pv = 1'b1; ep = 2'b00;
        end
      end else begin
        tag = "wb";
        dv  = 1'b1;
        ec.reg_write = 1'b1; ec.pc_en = 1'b1; ec.instret = 1'b1;
        pv = 1'b1;
        ep = (k == K_JAL) ? 2'b10 : (k == K_JALR) ? 2'b11 : 2'b00;
      end
      if (c == abort_at) begin
        tag = {"abort_", tag};
        r = 1'b1; ec = '0; dv = 1'b1; ed = '0; pv = 1'b1; ep = 2'b00;
      end
      step(r, ir, dr, bt, cv, ec, dv, ed, pv, ep, tag);
      if (c == abort_at) break;
    end
  endtask

  initial begin
    rst = 1'b1; instr_ready = 1'b0; data_ready = 1'b0; branch_taken = 1'b0; instr_code = '0;
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, '0, 1'b1, 8'h00,
           1'b1, 2'b00, "reset");

    run_instr(K_R,      32'h002081B3, 0, 0, 1'b0, -1);  // add x3,x1,x2
    run_instr(K_R,      32'h402081B3, 0, 0, 1'b0, -1);  // sub x3,x1,x2
    run_instr(K_LOAD,   32'h0040A283, 0, 3, 1'b0, -1);  // lw x5,4(x1)
    run_instr(K_BRANCH, 32'h00208463, 0, 0, 1'b1, -1);  // beq taken
    run_instr(K_BRANCH, 32'h00208463, 1, 0, 1'b0, -1);  // beq not taken
    run_instr(K_JALR,   32'h000100E7, 0, 0, 1'b0, -1);  // jalr x1,0(x2)
    run_instr(K_ILL,    32'h0000007F, 0, 0, 1'b0, -1);
    run_instr(K_I,      32'h40008093, 0, 0, 1'b0, -1);  // addi with bit30 set stays ADD
    run_instr(K_I,      32'h4010D093, 0, 0, 1'b0, -1);  // srai
    run_instr(K_R,      32'h002081B3, 12, 0, 1'b0, -1); // two fetch timeouts
    run_instr(K_R,      32'h002081B3, TO, 0, 1'b0, -1); // ready on the timeout cycle
    run_instr(K_STORE,  32'h0020A423, 0, 2, 1'b0, 3);   // sw aborted in first MEM cycle
    run_instr(K_STORE,  32'h0020A423, 0, 1, 1'b0, -1);

    for (int n = 0; n < 400; n++) begin
      kind_e k;
      int    f, d, ab;
      k  = kind_e'($urandom_range(0, 9));
      f  = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 13) : $urandom_range(0, 3);
      d  = $urandom_range(0, 4);
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, instr_len(k, f, d) - 1) : -1;
      run_instr(k, make_code(k), f, d, 1'($urandom), ab);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
